// File: rtl/wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// wb_trace_buffer
//
// Writeback-trace capture unit. Taps the WB stage of the pipelined core and
// records qualifying register writes as {timestamp, pc, rd, data} entries in a
// DEPTH-deep first-word-fall-through FIFO. A capture session is started by
// 'arm' and can wait for a trigger PC, filter by destination register, and run
// either stop-when-full or circular (overwrite oldest).
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   arm             start session: flush buffer, latch trig_en/trig_pc/circular
//   stop            end session (ARMED/CAPTURE -> DONE)
//   trig_en         sampled at arm: wait for trig_pc before capturing
//   trig_pc         sampled at arm: trigger PC
//   circular        sampled at arm: 1 = overwrite oldest when full
//   reg_mask        bit i enables capture of writes to x_i (bit 0 ignored)
//   wb_rf_enable    WB register write enable
//   wb_rd/wb_data   WB destination register and write data
//   wb_pc           PC of the WB instruction
//   rd_en           pop head entry
//   rd_entry        head entry {ts,pc,rd,data}; all zeros when empty
//   count           entries held
//   empty/full      count==0 / count==DEPTH
//   overflow        sticky: an event was dropped or overwritten this session
//   state           IDLE=0 ARMED=1 CAPTURE=2 DONE=3
//   timestamp       cycles since arm (saturating)
//
// Readout handshake: rd_entry always presents the head entry (FWFT) and is
// valid whenever empty==0. Asserting rd_en in a cycle where empty==0 consumes
// that entry at the clock edge; rd_en while empty is ignored. A pop is legal
// in every state but never happens in a cycle where arm is asserted.
// -----------------------------------------------------------------------------
module wb_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1,
    localparam int ENTRY_W = TS_W + PC_W + 5 + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic               stop,
    input  logic               trig_en,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic               circular,
    input  logic [31:0]        reg_mask,
    input  logic               wb_rf_enable,
    input  logic [4:0]         wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic [PC_W-1:0]    wb_pc,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_entry,
    output logic [CW-1:0]      count,
    output logic               empty,
    output logic               full,
    output logic               overflow,
    output logic [1:0]         state,
    output logic [TS_W-1:0]    timestamp
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [AW-1:0]       r_head;
    logic [AW-1:0]       r_tail;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       w_count_next;
    logic                r_overflow;
    logic [TS_W-1:0]     r_ts;
    logic [PC_W-1:0]     r_trig_pc;
    logic                r_circular;
    logic [ENTRY_W-1:0]  r_mem [DEPTH];

    logic w_qev;
    logic w_trig_hit;
    logic w_capture_en;
    logic w_push_req;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_write;
    logic w_drop;
    logic w_overwrite;
    logic w_active;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_active = (r_state == S_ARMED) || (r_state == S_CAPTURE);

    // x0 is never captured regardless of the mask.
    assign w_qev = wb_rf_enable && (wb_rd != 5'd0) && reg_mask[wb_rd];

    // The trigger write itself is eligible for capture in the trigger cycle.
    assign w_trig_hit   = (r_state == S_ARMED) && wb_rf_enable && (wb_pc == r_trig_pc);
    // arm and stop both suppress capture in their cycle.
    assign w_capture_en = !arm && !stop && ((r_state == S_CAPTURE) || w_trig_hit);
    assign w_push_req   = w_capture_en && w_qev;

    assign w_pop = !arm && rd_en && !w_empty;

    // A simultaneous pop frees a slot, so a push into a full buffer with a pop
    // is an ordinary write and never counts as an overflow.
    assign w_write     = w_push_req && (!w_full || w_pop || r_circular);
    assign w_drop      = w_push_req && w_full && !w_pop && !r_circular;
    assign w_overwrite = w_push_req && w_full && !w_pop && r_circular;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (arm) begin
            w_next_state = trig_en ? S_ARMED : S_CAPTURE;
        end else if (stop && w_active) begin
            w_next_state = S_DONE;
        end else if (w_drop) begin
            w_next_state = S_DONE;
        end else if (w_trig_hit) begin
            w_next_state = S_CAPTURE;
        end
    end

    // Occupancy: overwrite and push+pop both leave the count unchanged.
    always_comb begin
        w_count_next = r_count;
        if (w_write && !w_pop && !w_overwrite) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_write) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_ts       <= '0;
            r_trig_pc  <= '0;
            r_circular <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (arm) begin
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_ts       <= '0;
                r_trig_pc  <= trig_pc;
                r_circular <= circular;
            end else begin
                if (w_write) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop || w_overwrite) begin
                    r_head <= r_head + 1'b1;
                end
                r_count <= w_count_next;
                if (w_drop || w_overwrite) begin
                    r_overflow <= 1'b1;
                end
                if (w_active && (r_ts != '1)) begin
                    r_ts <= r_ts + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: rd_entry is gated by empty.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_tail] <= {r_ts, wb_pc, wb_rd, wb_data};
        end
    end

    assign rd_entry  = w_empty ? '0 : r_mem[r_head];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign state     = r_state;
    assign timestamp = r_ts;

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int EW     = TS_W + PC_W + 5 + DATA_W;
  localparam int SW     = 2 + CW + 3 + TS_W + EW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              arm = 1'b0;
  logic              stop = 1'b0;
  logic              trig_en = 1'b0;
  logic [PC_W-1:0]   trig_pc = '0;
  logic              circular = 1'b0;
  logic [31:0]       reg_mask = '1;
  logic              wb_rf_enable = 1'b0;
  logic [4:0]        wb_rd = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic [PC_W-1:0]   wb_pc = '0;
  logic              rd_en = 1'b0;
  logic [EW-1:0]     rd_entry;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic [1:0]        state;
  logic [TS_W-1:0]   timestamp;

  wb_trace_buffer #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en),
    .trig_pc(trig_pc), .circular(circular), .reg_mask(reg_mask),
    .wb_rf_enable(wb_rf_enable), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
    .rd_en(rd_en), .rd_entry(rd_entry), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .state(state), .timestamp(timestamp)
  );

  wire [SW-1:0] dut_status = {state, count, empty, full, overflow, timestamp, rd_entry};

  // ---------------- reference model ----------------
  logic [EW-1:0]   exp_q[$];
  logic [1:0]      m_state = 2'd0;
  logic            m_ovf = 1'b0;
  logic [TS_W-1:0] m_ts = '0;
  logic [PC_W-1:0] m_trig_pc = '0;
  logic            m_circ = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [SW-1:0] model_status();
    int n = exp_q.size();
    logic [EW-1:0] head = (n > 0) ? exp_q[0] : '0;
    return {m_state, CW'(n), (n == 0), (n == DEPTH), m_ovf, m_ts, head};
  endfunction

  // One clock of the trace unit described as session rules on a queue.
  task automatic model_step();
    logic [1:0] nxt;
    bit cap, qev, do_pop, live;
    int n;
    logic [EW-1:0] e;
    if (reset) begin
      exp_q.delete(); m_state = 2'd0; m_ovf = 1'b0; m_ts = '0; m_trig_pc = '0; m_circ = 1'b0;
    end else if (arm) begin
      exp_q.delete(); m_ovf = 1'b0; m_ts = '0;
      m_trig_pc = trig_pc; m_circ = circular;
      m_state = trig_en ? 2'd1 : 2'd2;
    end else begin
      nxt = m_state; cap = 0; n = exp_q.size();
      live = (m_state == 2'd1) || (m_state == 2'd2);
      qev = wb_rf_enable && (wb_rd != 0) && reg_mask[wb_rd];
      do_pop = rd_en && (n > 0);
      if (stop && live) nxt = 2'd3;
      else if (m_state == 2'd2) cap = 1;
      else if (m_state == 2'd1 && wb_rf_enable && wb_pc == m_trig_pc) begin
        nxt = 2'd2; cap = 1;
      end
      e = {m_ts, wb_pc, wb_rd, wb_data};
      if (do_pop) void'(exp_q.pop_front());
      if (cap && qev) begin
        if (n < DEPTH || do_pop) exp_q.push_back(e);
        else if (m_circ) begin void'(exp_q.pop_front()); exp_q.push_back(e); m_ovf = 1'b1; end
        else begin m_ovf = 1'b1; nxt = 2'd3; end
      end
      if (live && m_ts != '1) m_ts = m_ts + 1'b1;
      m_state = nxt;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; arm = 1'b0; stop = 1'b0; wb_rf_enable = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_arm(input logic te, input logic [PC_W-1:0] tp, input logic circ,
                        input logic [31:0] mask);
    trig_en = te; trig_pc = tp; circular = circ; reg_mask = mask; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_wb(input logic [4:0] rd, input logic [DATA_W-1:0] data,
                       input logic [PC_W-1:0] pc);
    wb_rf_enable = 1'b1; wb_rd = rd; wb_data = data; wb_pc = pc;
    tick();
    wb_rf_enable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_vec++;
    if (dut_status !== {2'd0, CW'(0), 1'b1, 1'b0, 1'b0, TS_W'(0), EW'(0)}) begin
      n_err++; $display("FAIL reset_state: got %h want all-idle/empty", dut_status);
    end
  endtask

  task automatic test_basic();
    logic [EW-1:0] want;
    do_arm(1'b0, '0, 1'b0, 32'hFFFF_FFFF);
    do_wb(5'd5, 32'h11, 32'h8);
    do_wb(5'd6, 32'h22, 32'hC);
    want = {TS_W'(0), PC_W'(32'h8), 5'd5, DATA_W'(32'h11)};
    n_vec++;
    if (count !== CW'(2) || rd_entry !== want) begin
      n_err++; $display("FAIL basic_head: count %0d entry %h want 2 %h", count, rd_entry, want);
    end
    n_vec++;
    if (dut_status !== model_status()) begin
      n_err++; $display("FAIL basic_model: got %h want %h", dut_status, model_status());
    end
  endtask

  task automatic test_trigger();
    do_arm(1'b1, 32'h10, 1'b0, 32'hFFFF_FFFF);
    do_wb(5'd1, 32'hA, 32'h4);
    do_wb(5'd2, 32'hB, 32'h8);
    n_vec++;
    if (state !== 2'd1 || count !== CW'(0)) begin
      n_err++; $display("FAIL trig_wait: state %0d count %0d want 1 0", state, count);
    end
    do_wb(5'd3, 32'hC, 32'h10);
    do_wb(5'd4, 32'hD, 32'h14);
    n_vec++;
    if (state !== 2'd2 || count !== CW'(2) || rd_entry[DATA_W+5 +: PC_W] !== PC_W'(32'h10)) begin
      n_err++; $display("FAIL trig_capture: state %0d count %0d pc %h want 2 2 10",
                        state, count, rd_entry[DATA_W+5 +: PC_W]);
    end
    n_vec++;
    if (dut_status !== model_status()) begin
      n_err++; $display("FAIL trig_model: got %h want %h", dut_status, model_status());
    end
  endtask

  task automatic test_stop_full();
    do_arm(1'b0, '0, 1'b0, 32'hFFFF_FFFF);
    for (int i = 1; i <= 17; i++) do_wb(5'(1 + i % 31), DATA_W'(i), PC_W'(4 * i));
    n_vec++;
    if (count !== CW'(16) || overflow !== 1'b1 || state !== 2'd3 || full !== 1'b1) begin
      n_err++; $display("FAIL stop_full: count %0d ovf %b state %0d want 16 1 3", count, overflow, state);
    end
    for (int k = 1; k <= 16; k++) begin
      n_vec++;
      if (rd_entry[DATA_W-1:0] !== DATA_W'(k) || dut_status !== model_status()) begin
        n_err++; $display("FAIL stop_drain: data %0d want %0d", rd_entry[DATA_W-1:0], k);
      end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    n_vec++;
    if (empty !== 1'b1 || rd_entry !== '0) begin
      n_err++; $display("FAIL stop_empty: empty %b entry %h want 1 0", empty, rd_entry);
    end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_vec++;
    if (count !== CW'(0) || dut_status !== model_status()) begin
      n_err++; $display("FAIL pop_on_empty: count %0d want 0", count);
    end
  endtask

  task automatic test_circular();
    do_arm(1'b0, '0, 1'b1, 32'hFFFF_FFFF);
    for (int i = 1; i <= 20; i++) do_wb(5'd7, DATA_W'(i), PC_W'(4 * i));
    n_vec++;
    if (count !== CW'(16) || overflow !== 1'b1 || state !== 2'd2 || rd_entry[DATA_W-1:0] !== DATA_W'(5)) begin
      n_err++; $display("FAIL circ_full: count %0d ovf %b state %0d head %0d want 16 1 2 5",
                        count, overflow, state, rd_entry[DATA_W-1:0]);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    for (int k = 5; k <= 20; k++) begin
      n_vec++;
      if (rd_entry[DATA_W-1:0] !== DATA_W'(k) || dut_status !== model_status()) begin
        n_err++; $display("FAIL circ_drain: data %0d want %0d", rd_entry[DATA_W-1:0], k);
      end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
  endtask

  task automatic test_mask_pushpop();
    do_arm(1'b0, '0, 1'b0, 32'h0000_0040);
    do_wb(5'd0, 32'h1, 32'h0);
    do_wb(5'd5, 32'h2, 32'h4);
    do_wb(5'd6, 32'h3, 32'h8);
    n_vec++;
    if (count !== CW'(1) || rd_entry[DATA_W +: 5] !== 5'd6) begin
      n_err++; $display("FAIL mask_filter: count %0d rd %0d want 1 6", count, rd_entry[DATA_W +: 5]);
    end
    for (int i = 0; i < 15; i++) do_wb(5'd6, DATA_W'($urandom), PC_W'(4 * i));
    rd_en = 1'b1; do_wb(5'd6, 32'hBEEF, 32'h100); rd_en = 1'b0;
    n_vec++;
    if (count !== CW'(16) || overflow !== 1'b0 || state !== 2'd2) begin
      n_err++; $display("FAIL full_pushpop: count %0d ovf %b state %0d want 16 0 2", count, overflow, state);
    end
    n_vec++;
    if (dut_status !== model_status()) begin
      n_err++; $display("FAIL pushpop_model: got %h want %h", dut_status, model_status());
    end
  endtask

  task automatic test_mid_reset();
    do_arm(1'b0, '0, 1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) do_wb(5'd9, DATA_W'($urandom), PC_W'(4 * i));
    n_vec++;
    if (count !== CW'(3)) begin
      n_err++; $display("FAIL pre_reset_count: got %0d want 3", count);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    n_vec++;
    if (state !== 2'd0 || count !== CW'(0) || empty !== 1'b1 || rd_entry !== '0) begin
      n_err++; $display("FAIL mid_reset: state %0d count %0d empty %b entry %h want 0 0 1 0",
                        state, count, empty, rd_entry);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 499) == 0);
      arm          = ($urandom_range(0, 59) == 0);
      stop         = ($urandom_range(0, 79) == 0);
      trig_en      = 1'($urandom);
      trig_pc      = PC_W'($urandom_range(0, 3) * 4);
      circular     = 1'($urandom);
      if (arm) reg_mask = $urandom | 32'h0F0F_0F0F;
      wb_rf_enable = ($urandom_range(0, 3) != 0);
      wb_rd        = 5'($urandom);
      wb_data      = DATA_W'($urandom);
      wb_pc        = PC_W'($urandom_range(0, 3) * 4);
      rd_en        = ($urandom_range(0, 3) == 0);
      tick();
      n_vec++;
      if (dut_status !== model_status()) begin
        n_err++; $display("FAIL random_cycle %0d: got %h want %h", c, dut_status, model_status());
      end
    end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_trigger();
    test_stop_full();
    test_circular();
    test_mask_pushpop();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
